// File: rtl/arb_req_agent.sv
// Requester agent for one arbiter port: queues burst commands, requests, and issues handshaked beats.
// Latency: command accepted at T0 -> req at T1 -> first beat at T3 with a free registered-grant arbiter.
// Backpressure: cmd_ready drops when the command FIFO is full; beat_ready low stalls the burst in place.
//
// Ports: clk/rst (async active-high); cmd_valid/cmd_len/cmd_ready/cmd_count (command side);
//        req/grant (arbiter side); beat_valid/beat_last/beat_ready (resource side); busy, err (status).

// Generic synchronous FIFO with registered full/empty/count; power-of-two depth.
// Latency: head entry visible the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushVld,
    input  logic [WIDTH-1:0] pushDat,
    input  logic             popVld,
    output logic [WIDTH-1:0] headDat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;
    logic [CNT_W-1:0] countNxt;

    assign doPush  = pushVld & ~full;
    assign doPop   = popVld & ~empty;
    assign headDat = mem[rdPtr];

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        countNxt = count;
        if (doPush && !doPop) begin
            countNxt = count + CNT_W'(1);
        end else if (doPop && !doPush) begin
            countNxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= countNxt;
            full  <= (countNxt == CNT_W'(DEPTH));
            empty <= (countNxt == '0);
        end
    end

    // Storage needs no reset: occupancy tracking masks stale entries.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushDat;
        end
    end
endmodule

module arb_req_agent #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic [CNT_W-1:0] cmd_count,
    output logic             req,
    input  logic             grant,
    output logic             beat_valid,
    output logic             beat_last,
    input  logic             beat_ready,
    output logic             busy,
    output logic             err
);
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        XFER = 4'b0100,
        REL  = 4'b1000
    } state_t;

    state_t           state;
    logic             reqReg;
    logic             errReg;
    logic [LEN_W-1:0] beatCnt;

    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [LEN_W-1:0] headLen;
    logic             pushFire;
    logic             popFire;
    logic             beatFire;

    // Registered full, but held off while reset is asserted so nothing is accepted then.
    assign cmd_ready = ~fifoFull & ~rst;
    assign pushFire  = cmd_valid & cmd_ready;
    // The head command is consumed exactly when the grant is seen in REQ.
    assign popFire   = (state == REQ) & grant;

    sync_fifo #(
        .WIDTH (LEN_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) cmdFifo (
        .clk     (clk),
        .rst     (rst),
        .pushVld (pushFire),
        .pushDat (cmd_len),
        .popVld  (popFire),
        .headDat (headLen),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifoCount)
    );

    // Beats are only offered while the grant is actually held.
    assign beat_valid = (state == XFER) & grant;
    assign beat_last  = beat_valid & (beatCnt == '0);
    assign beatFire   = beat_valid & beat_ready;

    assign cmd_count = fifoCount;
    assign req       = reqReg;
    assign err       = errReg;
    assign busy      = (state != IDLE) | ~fifoEmpty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            reqReg  <= 1'b0;
            errReg  <= 1'b0;
            beatCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        errReg <= 1'b1;
                    end
                    if (!fifoEmpty) begin
                        state  <= REQ;
                        reqReg <= 1'b1;
                    end
                end
                REQ: begin
                    if (grant) begin
                        state   <= XFER;
                        beatCnt <= headLen;
                    end
                end
                XFER: begin
                    // Lost grant mid-burst: flag it, keep req up, and wait for it to return.
                    if (!grant) begin
                        errReg <= 1'b1;
                    end else if (beatFire) begin
                        if (beatCnt == '0) begin
                            state  <= REL;
                            reqReg <= 1'b0;
                        end else begin
                            beatCnt <= beatCnt - LEN_W'(1);
                        end
                    end
                end
                REL: begin
                    // Hold req low until the arbiter has visibly released us, so it rotates.
                    if (!grant) begin
                        if (!fifoEmpty) begin
                            state  <= REQ;
                            reqReg <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    reqReg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arb_req_agent.sv
module tb_arb_req_agent;
    logic       clk;
    logic       rst;

    logic       cmdValid0, cmdValid1;
    logic [3:0] cmdLen0, cmdLen1;
    logic       cmdReady0, cmdReady1;
    logic [2:0] cmdCount0, cmdCount1;
    logic       req0, req1;
    logic       grant0, grant1;
    logic       bv0, bv1;
    logic       bl0, bl1;
    logic       br0, br1;
    logic       busy0, busy1;
    logic       err0, err1;

    int testsRun = 0;
    int testsFailed = 0;

    logic sbQ0[$];
    logic sbQ1[$];
    int   burstOrder[$];
    int   beats0 = 0;
    int   reqRises0 = 0;

    // Behavioural 2-port round-robin arbiter with registered grant.
    logic [1:0] arbG;
    logic       arbLast;
    logic       forceLow0;
    logic [1:0] reqV;

    assign reqV   = {req1, req0};
    assign grant0 = arbG[0] & ~forceLow0;
    assign grant1 = arbG[1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arbG    <= 2'b00;
            arbLast <= 1'b1;
        end else if (arbG != 2'b00) begin
            if ((arbG & reqV) == 2'b00) arbG <= 2'b00;
        end else if (reqV != 2'b00) begin
            if (reqV[0] && (arbLast || !reqV[1])) begin
                arbG    <= 2'b01;
                arbLast <= 1'b0;
            end else begin
                arbG    <= 2'b10;
                arbLast <= 1'b1;
            end
        end
    end

    arb_req_agent u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmdValid0), .cmd_len(cmdLen0),
        .cmd_ready(cmdReady0), .cmd_count(cmdCount0), .req(req0), .grant(grant0),
        .beat_valid(bv0), .beat_last(bl0), .beat_ready(br0), .busy(busy0), .err(err0)
    );

    arb_req_agent u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmdValid1), .cmd_len(cmdLen1),
        .cmd_ready(cmdReady1), .cmd_count(cmdCount1), .req(req1), .grant(grant1),
        .beat_valid(bv1), .beat_last(bl1), .beat_ready(br1), .busy(busy1), .err(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: every accepted beat pops its expected beat_last flag.
    initial begin : monitor
        logic expL;
        logic prevReq0;
        prevReq0 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bv0 && br0) begin
                    testsRun++;
                    if (sbQ0.size() == 0) begin
                        testsFailed++;
                        $display("FAIL sb0_extra_beat: unexpected beat on agent0, none required");
                    end else begin
                        expL = sbQ0.pop_front();
                        if (bl0 !== expL) begin
                            testsFailed++;
                            $display("FAIL sb0_last: got %0b required %0b", bl0, expL);
                        end
                        if (expL) burstOrder.push_back(0);
                    end
                    beats0++;
                end
                if (bv1 && br1) begin
                    testsRun++;
                    if (sbQ1.size() == 0) begin
                        testsFailed++;
                        $display("FAIL sb1_extra_beat: unexpected beat on agent1, none required");
                    end else begin
                        expL = sbQ1.pop_front();
                        if (bl1 !== expL) begin
                            testsFailed++;
                            $display("FAIL sb1_last: got %0b required %0b", bl1, expL);
                        end
                        if (expL) burstOrder.push_back(1);
                    end
                end
                if (bv0 || bv1) begin
                    testsRun++;
                    if (bv0 && bv1) begin
                        testsFailed++;
                        $display("FAIL beat_overlap: both agents valid, required at most one");
                    end
                end
                if (req0 && !prevReq0) reqRises0++;
            end
            prevReq0 = req0;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sbPush(input int port, input int len);
        for (int b = 0; b <= len; b++) begin
            if (port == 0) sbQ0.push_back(b == len);
            else           sbQ1.push_back(b == len);
        end
    endtask

    task automatic runIdle(input int maxCyc);
        int used;
        used = 0;
        do begin
            nextCycle();
            used++;
        end while ((busy0 || busy1) && used < maxCyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmdValid0 = 0; cmdValid1 = 0; cmdLen0 = 0; cmdLen1 = 0;
        br0 = 1'b1; br1 = 1'b1; forceLow0 = 1'b0;
        nextCycle();
        nextCycle();
        testsRun++;
        if ({req0, bv0, bl0, cmdReady0, busy0, err0, req1, bv1, cmdReady1, busy1, err1} !== 11'b0
            || cmdCount0 !== 3'd0) begin
            testsFailed++;
            $display("FAIL reset_outputs: got req=%0b bv=%0b rdy=%0b cnt=%0d busy=%0b err=%0b, required all 0",
                     req0, bv0, cmdReady0, cmdCount0, busy0, err0);
        end
        rst = 1'b0;
        #1;
        testsRun++;
        if (cmdReady0 !== 1'b1 || cmdReady1 !== 1'b1) begin
            testsFailed++;
            $display("FAIL reset_release_ready: got %0b/%0b required 1/1", cmdReady0, cmdReady1);
        end
    endtask

    task automatic test_single();
        // Per cycle T0..T8: {req, beat_valid, beat_last, busy}
        logic [3:0] expV [9];
        expV = '{4'b0001, 4'b1001, 4'b1001, 4'b1101, 4'b1101, 4'b1111, 4'b0001, 4'b0001, 4'b0000};
        br0 = 1'b1;
        cmdValid0 = 1'b1; cmdLen0 = 4'd2; sbPush(0, 2);
        for (int i = 0; i < 9; i++) begin
            nextCycle();
            if (i == 0) begin
                cmdValid0 = 1'b0;
                testsRun++;
                if (cmdCount0 !== 3'd1) begin
                    testsFailed++;
                    $display("FAIL single_count_T0: got %0d required 1", cmdCount0);
                end
            end
            testsRun++;
            if ({req0, bv0, bl0, busy0} !== expV[i]) begin
                testsFailed++;
                $display("FAIL single_T%0d: got {req,bv,bl,busy}=%4b required %4b", i, {req0, bv0, bl0, busy0}, expV[i]);
            end
        end
        testsRun++;
        if (sbQ0.size() != 0 || err0 !== 1'b0) begin
            testsFailed++;
            $display("FAIL single_end: got sb=%0d err=%0b required 0/0", sbQ0.size(), err0);
        end
    endtask

    task automatic test_stall();
        logic readyPat [5];
        logic expBl [5];
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        expBl    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cmdValid0 = 1'b1; cmdLen0 = 4'd2; sbPush(0, 2);
        nextCycle();
        cmdValid0 = 1'b0;
        nextCycle();
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            br0 = readyPat[i];
            testsRun++;
            if ({req0, bv0, bl0} !== {1'b1, 1'b1, expBl[i]}) begin
                testsFailed++;
                $display("FAIL stall_cyc%0d: got {req,bv,bl}=%3b required %3b", i, {req0, bv0, bl0}, {2'b11, expBl[i]});
            end
        end
        nextCycle();
        testsRun++;
        if ({req0, bv0} !== 2'b00) begin
            testsFailed++;
            $display("FAIL stall_rel: got {req,bv}=%2b required 00", {req0, bv0});
        end
        br0 = 1'b1;
        runIdle(50);
        testsRun++;
        if (busy0 !== 1'b0 || sbQ0.size() != 0) begin
            testsFailed++;
            $display("FAIL stall_end: got busy=%0b sb=%0d required 0/0", busy0, sbQ0.size());
        end
    endtask

    task automatic test_four();
        forceLow0 = 1'b1;
        beats0 = 0;
        reqRises0 = 0;
        for (int k = 0; k < 4; k++) begin
            cmdValid0 = 1'b1; cmdLen0 = 4'(k); sbPush(0, k);
            nextCycle();
        end
        testsRun++;
        if (cmdCount0 !== 3'd4 || cmdReady0 !== 1'b0) begin
            testsFailed++;
            $display("FAIL four_full: got cnt=%0d rdy=%0b required 4/0", cmdCount0, cmdReady0);
        end
        cmdLen0 = 4'd5;
        nextCycle();
        cmdValid0 = 1'b0;
        testsRun++;
        if (cmdCount0 !== 3'd4 || req0 !== 1'b1) begin
            testsFailed++;
            $display("FAIL four_push_when_full: got cnt=%0d req=%0b required 4/1", cmdCount0, req0);
        end
        forceLow0 = 1'b0;
        runIdle(300);
        testsRun++;
        if (busy0 !== 1'b0 || beats0 != 10 || cmdCount0 !== 3'd0) begin
            testsFailed++;
            $display("FAIL four_total: got busy=%0b beats=%0d cnt=%0d required 0/10/0", busy0, beats0, cmdCount0);
        end
        testsRun++;
        if (reqRises0 != 4 || sbQ0.size() != 0 || err0 !== 1'b0) begin
            testsFailed++;
            $display("FAIL four_req_gaps: got rises=%0d sb=%0d err=%0b required 4/0/0", reqRises0, sbQ0.size(), err0);
        end
    endtask

    task automatic test_two_agents();
        burstOrder.delete();
        for (int k = 0; k < 3; k++) begin
            cmdValid0 = 1'b1; cmdLen0 = 4'd1; sbPush(0, 1);
            cmdValid1 = 1'b1; cmdLen1 = 4'd1; sbPush(1, 1);
            nextCycle();
        end
        cmdValid0 = 1'b0; cmdValid1 = 1'b0;
        runIdle(400);
        testsRun++;
        if (burstOrder.size() != 6 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            testsFailed++;
            $display("FAIL two_bursts: got bursts=%0d busy=%0b/%0b required 6/0/0", burstOrder.size(), busy0, busy1);
        end
        for (int i = 1; i < burstOrder.size(); i++) begin
            testsRun++;
            if (burstOrder[i] == burstOrder[i-1]) begin
                testsFailed++;
                $display("FAIL two_alternate_%0d: got port %0d twice, required alternation", i, burstOrder[i]);
            end
        end
        testsRun++;
        if (err0 !== 1'b0 || err1 !== 1'b0 || cmdCount1 !== 3'd0) begin
            testsFailed++;
            $display("FAIL two_err: got err=%0b/%0b cnt1=%0d required 0/0/0", err0, err1, cmdCount1);
        end
    endtask

    task automatic test_grant_drop();
        cmdValid0 = 1'b1; cmdLen0 = 4'd3; sbPush(0, 3);
        nextCycle();
        cmdValid0 = 1'b0;
        nextCycle();
        nextCycle();
        nextCycle();
        testsRun++;
        if (bv0 !== 1'b1) begin
            testsFailed++;
            $display("FAIL gdrop_first_beat: got bv=%0b required 1", bv0);
        end
        nextCycle();
        forceLow0 = 1'b1;
        #1;
        testsRun++;
        if (bv0 !== 1'b0 || req0 !== 1'b1) begin
            testsFailed++;
            $display("FAIL gdrop_stall1: got bv=%0b req=%0b required 0/1", bv0, req0);
        end
        nextCycle();
        testsRun++;
        if (bv0 !== 1'b0 || err0 !== 1'b1) begin
            testsFailed++;
            $display("FAIL gdrop_stall2: got bv=%0b err=%0b required 0/1", bv0, err0);
        end
        forceLow0 = 1'b0;
        #1;
        testsRun++;
        if (bv0 !== 1'b1) begin
            testsFailed++;
            $display("FAIL gdrop_resume: got bv=%0b required 1", bv0);
        end
        runIdle(50);
        testsRun++;
        if (busy0 !== 1'b0 || sbQ0.size() != 0 || err0 !== 1'b1) begin
            testsFailed++;
            $display("FAIL gdrop_end: got busy=%0b sb=%0d err=%0b required 0/0/1", busy0, sbQ0.size(), err0);
        end
    endtask

    task automatic test_reset_mid();
        cmdValid0 = 1'b1; cmdLen0 = 4'd3; sbPush(0, 3);
        nextCycle();
        cmdValid0 = 1'b0;
        nextCycle();
        nextCycle();
        nextCycle();
        nextCycle();
        rst = 1'b1;
        #1;
        testsRun++;
        if ({req0, bv0, bl0, cmdReady0, busy0, err0} !== 6'b0 || cmdCount0 !== 3'd0) begin
            testsFailed++;
            $display("FAIL rstmid_outputs: got req=%0b bv=%0b bl=%0b rdy=%0b busy=%0b err=%0b cnt=%0d required all 0",
                     req0, bv0, bl0, cmdReady0, busy0, err0, cmdCount0);
        end
        sbQ0.delete();
        sbQ1.delete();
        nextCycle();
        rst = 1'b0;
        #1;
        testsRun++;
        if (cmdReady0 !== 1'b1 || cmdCount0 !== 3'd0) begin
            testsFailed++;
            $display("FAIL rstmid_release: got rdy=%0b cnt=%0d required 1/0", cmdReady0, cmdCount0);
        end
        beats0 = 0;
        cmdValid0 = 1'b1; cmdLen0 = 4'd1; sbPush(0, 1);
        nextCycle();
        cmdValid0 = 1'b0;
        runIdle(50);
        testsRun++;
        if (busy0 !== 1'b0 || sbQ0.size() != 0 || beats0 != 2 || err0 !== 1'b0) begin
            testsFailed++;
            $display("FAIL rstmid_fresh: got busy=%0b sb=%0d beats=%0d err=%0b required 0/0/2/0",
                     busy0, sbQ0.size(), beats0, err0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_four();
        test_two_agents();
        test_grant_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
